bitwise_logic_unit: RTL and testbench



---
 rtl/bitwise_logic_unit.sv | 90 +++++++++
 tb/tb_bitwise_logic_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_unit.sv
// bitwise_logic_unit: WIDTH-bit eight-operation logic unit, two register stages with valid/ready
// handshakes and an accumulator that can replace operand x. Result flags built with BITLOGIC_FLAGS_EN.
module bitwise_logic_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  input  logic             chain,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] f,
  output logic             out_valid,
  input  logic             out_ready
`ifdef BITLOGIC_FLAGS_EN
  ,
  output logic             zero,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] s1_result;
  logic             s1_valid;
  logic             s2_load;
  logic             accept;

  // S2 can take a new value whenever it is empty or its current value leaves this cycle.
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = reset_n && (!s1_valid || s2_load);
  assign accept   = in_valid && in_ready;

  always_comb begin
    a = chain ? acc : x;
    r = a;
    case (op)
      3'b000: r = a & y;
      3'b001: r = a | y;
      3'b010: r = a ^ y;
      3'b011: r = ~(a & y);
      3'b100: r = ~(a | y);
      3'b101: r = ~(a ^ y);
      3'b110: r = a & ~y;
      3'b111: r = a;
      default: r = a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_result <= '0;
      out_valid <= 1'b0;
      f         <= '0;
      acc       <= '0;
    end else begin
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          f <= s1_result;
        end
      end
      if (accept) begin
        s1_valid  <= 1'b1;
        s1_result <= r;
        acc       <= r;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

`ifdef BITLOGIC_FLAGS_EN
  // Flags travel with f so they stay coherent with it under backpressure.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      zero   <= 1'b1;
      parity <= 1'b0;
    end else if (s2_load && s1_valid) begin
      zero   <= (s1_result == '0);
      parity <= ^s1_result;
    end
  end
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// tb_bitwise_logic_unit: randomized and directed checks of bitwise_logic_unit against a
// truth-table reference model with an occupancy/latency queue model.
module tb_bitwise_logic_unit;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] r;
    int           t;
  } ent_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [2:0]   op = '0;
  logic         chain = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready;
  logic [W-1:0] f;
  logic         out_valid;
`ifdef BITLOGIC_FLAGS_EN
  logic         zero;
  logic         parity;
`endif

  int           vectors = 0;
  int           errors = 0;
  int           ticks = 0;
  logic [W-1:0] m_acc = '0;
  ent_t         q[$];

  bitwise_logic_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .op(op), .chain(chain),
    .in_valid(in_valid), .in_ready(in_ready), .f(f), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef BITLOGIC_FLAGS_EN
    , .zero(zero), .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  // Each op as a 2-input truth table indexed by {a_bit, y_bit}, applied bit by bit.
  function automatic logic [W-1:0] ref_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                                          input logic [2:0] o);
    logic [3:0]   tt;
    logic [W-1:0] res;
    case (o)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0110;
      3'd3: tt = 4'b0111;
      3'd4: tt = 4'b0001;
      3'd5: tt = 4'b1001;
      3'd6: tt = 4'b0100;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < W; i++) res[i] = tt[{av[i], bv[i]}];
    return res;
  endfunction

  // A result accepted at edge A is visible from edge A+1 on, once it is the oldest in flight.
  function automatic bit exp_valid();
    return (q.size() > 0) && (q[0].t + 1 <= ticks);
  endfunction

  // At most two results in flight; a third is refused only while the output is stalled.
  function automatic bit exp_ready();
    return reset_n && !(q.size() >= 2 && !out_ready);
  endfunction

  task automatic tick(output bit accepted);
    bit           take;
    bit           rst_low;
    logic [W-1:0] res;
    accepted = in_valid && exp_ready();
    take     = exp_valid() && out_ready;
    rst_low  = !reset_n;
    res      = ref_op(chain ? m_acc : x, y, op);
    @(posedge clk);
    ticks++;
    if (rst_low) begin
      q.delete();
      m_acc = '0;
    end else begin
      if (take) void'(q.pop_front());
      if (accepted) begin
        q.push_back('{r: res, t: ticks});
        m_acc = res;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit a;
    reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    x = $urandom; y = $urandom; op = 3'($urandom_range(0, 7));
    repeat (2) begin
      tick(a);
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      vectors++;
      if (f !== '0) begin errors++; $display("FAIL reset_f got %h want 0", f); end
      vectors++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
`ifdef BITLOGIC_FLAGS_EN
      vectors++;
      if (zero !== 1'b1 || parity !== 1'b0) begin
        errors++; $display("FAIL reset_flags got zero=%b parity=%b want 1 0", zero, parity);
      end
`endif
    end
    reset_n = 1'b1; in_valid = 1'b0;
    repeat (3) begin
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got %b want 0", out_valid); end
      vectors++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
      tick(a);
    end
  endtask

  task automatic test_all_ops();
    logic [W-1:0] expv [8];
    int k = 0;
    int t_first = 0;
    bit a;
    expv = '{32'hF000_0034, 32'hFFF0_12FF, 32'h0FF0_12CB, 32'h0FFF_FFCB,
             32'h000F_ED00, 32'hF00F_ED34, 32'h00F0_1200, 32'hF0F0_1234};
    x = 32'hF0F0_1234; y = 32'hFF00_00FF; chain = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8);
      op = 3'(c);
      #1;
      if (out_valid === 1'b1 && k < 8) begin
        if (k == 0) begin
          vectors++;
          if (ticks - t_first !== 1) begin
            errors++; $display("FAIL ops_latency got %0d want 1 edges after accept", ticks - t_first);
          end
        end
        vectors++;
        if (f !== expv[k]) begin errors++; $display("FAIL ops_result[%0d] got %h want %h", k, f, expv[k]); end
        k++;
      end else if (k > 0 && k < 8) begin
        vectors++; errors++;
        $display("FAIL ops_gap got out_valid=%b want 1 at result %0d", out_valid, k);
      end
      tick(a);
      if (c == 0) t_first = ticks;
    end
    vectors++;
    if (k != 8) begin errors++; $display("FAIL ops_count got %0d want 8", k); end
  endtask

  task automatic test_chain();
    logic [W-1:0] cy [3];
    logic [2:0]   co [3];
    logic [W-1:0] expv [3];
    int k = 0;
    bit a;
    cy = '{32'h2, 32'h4, 32'hF};
    co = '{3'd1, 3'd1, 3'd2};
    expv = '{32'h3, 32'h7, 32'h8};
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 3);
      if (c < 3) begin
        x = (c == 0) ? 32'h1 : W'($urandom);
        y = cy[c]; op = co[c]; chain = (c != 0);
      end
      #1;
      if (out_valid === 1'b1 && k < 3) begin
        vectors++;
        if (f !== expv[k]) begin errors++; $display("FAIL chain_result[%0d] got %h want %h", k, f, expv[k]); end
        k++;
      end
      tick(a);
    end
    vectors++;
    if (k != 3) begin errors++; $display("FAIL chain_count got %0d want 3", k); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] sx [4];
    logic [W-1:0] sy [4];
    logic [2:0]   so [4];
    logic [W-1:0] held = '0;
    int idx = 0, got = 0, stall = 0;
    bit started = 0, saw_full = 0, a;
    for (int i = 0; i < 4; i++) begin
      sx[i] = $urandom; sy[i] = $urandom; so[i] = 3'($urandom_range(0, 7));
    end
    chain = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 30 && (idx < 4 || q.size() > 0); c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin x = sx[idx]; y = sy[idx]; op = so[idx]; end
      if (!started && out_valid === 1'b1) begin
        started = 1; stall = 5; held = f;
      end
      out_ready = (stall == 0);
      #1;
      if (q.size() >= 2 && !out_ready) begin
        saw_full = 1;
        vectors++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
      end
      if (stall > 0) begin
        vectors++;
        if (f !== held || out_valid !== 1'b1) begin
          errors++; $display("FAIL bp_hold got f=%h v=%b want f=%h v=1", f, out_valid, held);
        end
        stall--;
      end
      vectors++;
      if (out_valid !== exp_valid()) begin errors++; $display("FAIL bp_out_valid got %b want %b", out_valid, exp_valid()); end
      if (exp_valid()) begin
        vectors++;
        if (f !== q[0].r) begin errors++; $display("FAIL bp_result got %h want %h", f, q[0].r); end
        if (out_ready) got++;
      end
      tick(a);
      if (a) idx++;
    end
    out_ready = 1'b1;
    vectors++;
    if (got != 4 || !saw_full) begin
      errors++; $display("FAIL bp_complete got %0d results full=%b want 4 full=1", got, saw_full);
    end
  endtask

  task automatic test_random();
    bit a;
    for (int c = 0; c < 400; c++) begin
      if (c < 390) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        x = $urandom; y = $urandom;
        op = 3'($urandom_range(0, 7));
        chain = $urandom_range(0, 1) != 0;
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      #1;
      vectors++;
      if (out_valid !== exp_valid()) begin errors++; $display("FAIL rnd_out_valid cyc %0d got %b want %b", c, out_valid, exp_valid()); end
      vectors++;
      if (in_ready !== exp_ready()) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", c, in_ready, exp_ready()); end
      if (exp_valid()) begin
        vectors++;
        if (f !== q[0].r) begin errors++; $display("FAIL rnd_result cyc %0d got %h want %h", c, f, q[0].r); end
`ifdef BITLOGIC_FLAGS_EN
        vectors++;
        if (zero !== (q[0].r == 0) || parity !== ($countones(q[0].r) % 2 == 1)) begin
          errors++; $display("FAIL rnd_flags cyc %0d got zero=%b parity=%b for %h", c, zero, parity, q[0].r);
        end
`endif
      end
      tick(a);
    end
  endtask

  task automatic test_reset_mid();
    bit a;
    int k;
    out_ready = 1'b0; in_valid = 1'b1; chain = 1'b0;
    for (int c = 0; c < 6 && q.size() < 2; c++) begin
      x = $urandom | 32'h1; y = $urandom; op = 3'd1;
      #1;
      tick(a);
    end
    #1;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_full got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
    end
    reset_n = 1'b0;
    tick(a);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset got out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
    end
    reset_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; chain = 1'b1; op = 3'd7; x = 32'hDEAD_BEEF; y = $urandom;
    #1;
    tick(a);
    in_valid = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 4) begin tick(a); k++; end
    vectors++;
    if (out_valid !== 1'b1 || f !== '0) begin
      errors++; $display("FAIL mid_chain_pass got v=%b f=%h want v=1 f=0", out_valid, f);
    end
    tick(a);
  endtask

`ifdef BITLOGIC_FLAGS_EN
  task automatic test_flags();
    bit a;
    int k = 0;
    logic [W-1:0] ef [2];
    logic         ez [2];
    logic         ep [2];
    ef = '{32'h0, 32'h1}; ez = '{1'b1, 1'b0}; ep = '{1'b0, 1'b1};
    out_ready = 1'b1; chain = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 2);
      x = (c == 0) ? 32'hAAAA_AAAA : 32'h1;
      y = (c == 0) ? 32'hAAAA_AAAA : 32'h0;
      op = (c == 0) ? 3'd2 : 3'd1;
      #1;
      if (out_valid === 1'b1 && k < 2) begin
        vectors++;
        if (f !== ef[k] || zero !== ez[k] || parity !== ep[k]) begin
          errors++;
          $display("FAIL flags[%0d] got f=%h z=%b p=%b want f=%h z=%b p=%b", k, f, zero, parity, ef[k], ez[k], ep[k]);
        end
        k++;
      end
      tick(a);
    end
    vectors++;
    if (k != 2) begin errors++; $display("FAIL flags_count got %0d want 2", k); end
  endtask
`endif

  initial begin
    test_reset();
    test_all_ops();
    test_chain();
    test_backpressure();
    test_random();
`ifdef BITLOGIC_FLAGS_EN
    test_flags();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
